alu_arbiter: RTL and testbench

Shares a single `ALU` instance between two requesters: requester 0 is the execute-stage sequencer and requester 1 is the address-generation sequencer. The block accepts one operation per handshake and arbitrates round-robin on contention. It holds the operation in a one-entry operand register and returns the result to the owning requester over a valid/ready response channel. It sits between the control sequencers and the datapath, and is the only path by which either requester reaches the ALU.

---
 rtl/alu_pkg.sv | 17 +
 rtl/ALU.sv | 25 ++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU and every block that drives it.
package alu_pkg;

    // Operand / result width used by the datapath.
    localparam int ALU_WIDTH = 16;

    // Operation select encodings.
    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_XOR   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    // Requester indices seen by the ALU arbiter.
    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_AGEN = 1'b1;

endpackage

// File: rtl/ALU.sv
// Combinational ALU: ADD (wrapping), AND, XOR, PASSA. No flags.
module ALU
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       aluk_i,
    output logic [WIDTH-1:0] y_o
);

    // Select the result of the requested operation.
    always_comb begin
        y_o = a_i;
        case (aluk_i)
            ALUK_ADD:   y_o = a_i + b_i;
            ALUK_AND:   y_o = a_i & b_i;
            ALUK_XOR:   y_o = a_i ^ b_i;
            ALUK_PASSA: y_o = a_i;
            default:    y_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute sequencer (0) and the address-generation
// sequencer (1). Round-robin grant on contention, one-entry operand register,
// result returned on a per-requester valid/ready channel with shared data.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_aluk,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_aluk,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,

    output logic             busy
);

    // Held operation and arbitration state.
    logic             full_q,  full_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;
    logic [1:0]       op_k_q,  op_k_d;

    logic             owner_rsp_ready;
    logic             drain;
    logic             slot_free;
    logic             gnt_vld;
    logic             gnt_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_k;

    // Response side: only the owner's ready can release the slot.
    always_comb begin
        owner_rsp_ready = (owner_q == REQ_AGEN) ? rsp1_ready : rsp0_ready;
        drain           = full_q && owner_rsp_ready;
        slot_free       = !full_q || drain;
    end

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = REQ_EXEC;
        if (req0_valid && req1_valid) begin
            gnt_vld = 1'b1;
            gnt_idx = ~last_q;
        end else if (req0_valid) begin
            gnt_vld = 1'b1;
            gnt_idx = REQ_EXEC;
        end else if (req1_valid) begin
            gnt_vld = 1'b1;
            gnt_idx = REQ_AGEN;
        end
    end

    // Ready is withheld during reset so a requester never sees a handshake
    // that the state registers will not record.
    always_comb begin
        accept     = slot_free && gnt_vld && !rst;
        req0_ready = accept && (gnt_idx == REQ_EXEC);
        req1_ready = accept && (gnt_idx == REQ_AGEN);
    end

    // Operand mux towards the operand register.
    always_comb begin
        sel_a = (gnt_idx == REQ_AGEN) ? req1_a    : req0_a;
        sel_b = (gnt_idx == REQ_AGEN) ? req1_b    : req0_b;
        sel_k = (gnt_idx == REQ_AGEN) ? req1_aluk : req0_aluk;
    end

    // Next state: load on accept (which may coincide with a drain), clear on drain alone.
    always_comb begin
        full_d  = full_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_k_d  = op_k_q;
        if (accept) begin
            full_d  = 1'b1;
            owner_d = gnt_idx;
            last_d  = gnt_idx;
            op_a_d  = sel_a;
            op_b_d  = sel_b;
            op_k_d  = sel_k;
        end else if (drain) begin
            full_d  = 1'b0;
        end
    end

    // State registers; reset discards any held operation and favours requester 0 next.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            owner_q <= REQ_EXEC;
            last_q  <= REQ_AGEN;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_k_q  <= ALUK_ADD;
        end else begin
            full_q  <= full_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_k_q  <= op_k_d;
        end
    end

    // The single shared ALU, fed straight from the operand register.
    ALU #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .aluk_i (op_k_q),
        .y_o    (rsp_data)
    );

    // Response and status outputs.
    always_comb begin
        rsp0_valid = full_q && (owner_q == REQ_EXEC);
        rsp1_valid = full_q && (owner_q == REQ_AGEN);
        busy       = full_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single ops with wrap, tie break,
// back-pressure, alternating stream, reset with a held result.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_aluk, req1_aluk;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_aluk  (req0_aluk),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_aluk  (req1_aluk),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
        req0_valid = v; req0_aluk = k; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
        req1_valid = v; req1_aluk = k; req1_a = a; req1_b = b;
    endtask

    initial begin
        rst = 1'b1;
        drive0(1'b0, 2'd0, 16'h0, 16'h0);
        drive1(1'b0, 2'd0, 16'h0, 16'h0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp0v", rsp0_valid, 0);
        chk("rst_rsp1v", rsp1_valid, 0);

        // Single request: ADD 7FFF+0001, then back-to-back ADD FFFF+0002 (wraps).
        tick();
        rst = 1'b0;
        drive0(1'b1, 2'd0, 16'h7FFF, 16'h0001);
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("single_rdy0", req0_ready, 1);
        chk("single_rdy1", req1_ready, 0);
        tick();
        drive0(1'b1, 2'd0, 16'hFFFF, 16'h0002);
        @(negedge clk);
        chk("single_rsp0v", rsp0_valid, 1);
        chk("single_rsp1v", rsp1_valid, 0);
        chk("single_data", rsp_data, 16'h8000);
        chk("single_busy", busy, 1);
        chk("b2b_rdy0", req0_ready, 1);
        tick();
        drive0(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("wrap_rsp0v", rsp0_valid, 1);
        chk("wrap_data", rsp_data, 16'h0001);
        tick();
        @(negedge clk);
        chk("drained_busy", busy, 0);
        chk("drained_rsp0v", rsp0_valid, 0);

        // Tie in the first cycle after reset: requester 0 wins.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive0(1'b1, 2'd1, 16'hF0F0, 16'h0FF0);
        drive1(1'b1, 2'd2, 16'hAAAA, 16'hFFFF);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("tie_rdy0", req0_ready, 1);
        chk("tie_rdy1", req1_ready, 0);
        tick();
        drive0(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("tie_rsp0v", rsp0_valid, 1);
        chk("tie_and_data", rsp_data, 16'h00F0);
        chk("tie_next_rdy1", req1_ready, 1);
        tick();
        drive1(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("tie_rsp1v", rsp1_valid, 1);
        chk("tie_rsp0v_low", rsp0_valid, 0);
        chk("tie_xor_data", rsp_data, 16'h5555);
        tick();

        // Back-pressure on requester 1 with a PASSA result held.
        rsp1_ready = 1'b0;
        drive1(1'b1, 2'd3, 16'h1234, 16'hBEEF);
        @(negedge clk);
        chk("bp_rdy1", req1_ready, 1);
        tick();
        drive0(1'b1, 2'd0, 16'h0001, 16'h0001);
        drive1(1'b1, 2'd2, 16'h0F0F, 16'h00FF);
        rsp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rsp1v", rsp1_valid, 1);
            chk("bp_rsp0v", rsp0_valid, 0);
            chk("bp_data", rsp_data, 16'h1234);
            chk("bp_rdy0", req0_ready, 0);
            chk("bp_rdy1_low", req1_ready, 0);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("rel_data", rsp_data, 16'h1234);
        chk("rel_rdy0", req0_ready, 1);
        chk("rel_rdy1", req1_ready, 0);

        // Streaming: both requesters always valid, grants alternate every cycle.
        tick();
        drive0(1'b1, 2'd0, 16'h1000, 16'h0234);
        @(negedge clk);
        chk("st1_rsp0v", rsp0_valid, 1);
        chk("st1_data", rsp_data, 16'h0002);
        chk("st1_rdy1", req1_ready, 1);
        chk("st1_rdy0", req0_ready, 0);
        tick();
        drive1(1'b1, 2'd1, 16'hFFFF, 16'h00FF);
        @(negedge clk);
        chk("st2_rsp1v", rsp1_valid, 1);
        chk("st2_data", rsp_data, 16'h0FF0);
        chk("st2_rdy0", req0_ready, 1);
        chk("st2_rdy1", req1_ready, 0);
        tick();
        drive0(1'b1, 2'd3, 16'h5A5A, 16'h0000);
        @(negedge clk);
        chk("st3_rsp0v", rsp0_valid, 1);
        chk("st3_data", rsp_data, 16'h1234);
        chk("st3_rdy1", req1_ready, 1);
        tick();
        drive1(1'b1, 2'd0, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        chk("st4_rsp1v", rsp1_valid, 1);
        chk("st4_data", rsp_data, 16'h00FF);
        chk("st4_rdy0", req0_ready, 1);
        tick();
        drive0(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("st5_rsp0v", rsp0_valid, 1);
        chk("st5_data", rsp_data, 16'h5A5A);
        chk("st5_rdy1", req1_ready, 1);
        tick();
        drive1(1'b0, 2'd0, 16'h0, 16'h0);
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("st6_rsp1v", rsp1_valid, 1);
        chk("st6_data", rsp_data, 16'hFFFE);
        chk("st6_busy", busy, 1);

        // Reset while the requester-1 result is held; req0 valid during reset is not taken.
        tick();
        rst = 1'b1;
        drive0(1'b1, 2'd0, 16'h0003, 16'h0004);
        @(negedge clk);
        chk("rstop_rdy0", req0_ready, 0);
        tick();
        rst = 1'b0;
        drive0(1'b0, 2'd0, 16'h0, 16'h0);
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("rstop_rsp1v", rsp1_valid, 0);
        chk("rstop_busy", busy, 0);
        chk("rstop_rsp0v", rsp0_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rstop_norsp1", rsp1_valid, 0);
            chk("rstop_nobusy", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
